// File: rtl/flit_source_if.sv
// Injection-port bundle for flit_source: packet request handshake,
// outgoing channel word and incoming credit returns.
interface flit_source_if #(
    parameter int vc_w    = 3,
    parameter int len_w   = 3,
    parameter int route_w = 14,
    parameter int fdw     = 64
);
    logic                   pkt_req_valid;
    logic                   pkt_req_ready;
    logic [vc_w-1:0]        pkt_req_vc;
    logic [len_w-1:0]       pkt_req_length;
    logic [route_w-1:0]     pkt_req_route_info;
    // {link_active, valid, vc, head, tail, data}
    logic [vc_w+fdw+3:0]    channel;
    // {credit_valid, credit_vc}
    logic [vc_w:0]          flow_ctrl;

    modport master (
        output pkt_req_valid, pkt_req_vc, pkt_req_length, pkt_req_route_info, flow_ctrl,
        input  pkt_req_ready, channel
    );

    modport slave (
        input  pkt_req_valid, pkt_req_vc, pkt_req_length, pkt_req_route_info, flow_ctrl,
        output pkt_req_ready, channel
    );
endinterface

// File: rtl/flit_source.sv
// Credit-based packet injector: serialises one packet request at a time into
// head/body/tail flits, gated by a per-VC downstream credit counter.
//
//  state | meaning
//  IDLE  | ready for a packet request; channel link inactive
//  SEND  | emitting flits of the latched packet, stalling while its VC has no credit
module flit_source #(
    parameter int num_vcs                = 8,
    parameter int buffer_size            = 64,
    parameter int max_packet_length      = 8,
    parameter int route_info_width       = 14,
    parameter int flit_data_width        = 64,
    parameter int packet_count_reg_width = 32,
    parameter int num_dimensions         = 2,
    parameter int num_routers            = 16,
    localparam int vc_idx_width      = $clog2(num_vcs),
    localparam int len_width         = $clog2(max_packet_length),
    // dims * clog2(croot(routers, dims)) == dims * ceil(clog2(routers) / dims)
    localparam int router_addr_width = num_dimensions *
                   (($clog2(num_routers) + num_dimensions - 1) / num_dimensions)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [router_addr_width-1:0]      router_address_i,
    flit_source_if.slave                      bus,
    output logic [packet_count_reg_width-1:0] pkt_count_o,
    output logic                              error_o
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam int credits_per_vc = buffer_size / num_vcs;
    localparam int cred_w         = $clog2(credits_per_vc + 1);
    localparam int pad_w          = flit_data_width - route_info_width - 8
                                    - packet_count_reg_width - router_addr_width;
    localparam logic [cred_w-1:0]       cred_max  = cred_w'(credits_per_vc);
    localparam logic [vc_idx_width:0]   num_vcs_c = (vc_idx_width + 1)'(num_vcs);

    state_t                              state_q, state_d;
    logic [vc_idx_width-1:0]             vc_q, vc_d;
    logic [len_width-1:0]                len_q, len_d;
    logic [len_width-1:0]                idx_q, idx_d;
    logic [route_info_width-1:0]         route_q, route_d;
    logic [packet_count_reg_width-1:0]   seq_q, seq_d;
    logic [packet_count_reg_width-1:0]   pkt_count_q, pkt_count_d;
    logic                                error_q, error_d;
    logic [cred_w-1:0]                   credit_q [num_vcs];
    logic [cred_w-1:0]                   credit_d [num_vcs];

    logic                                link_q, link_d;
    logic                                valid_q, valid_d;
    logic [vc_idx_width-1:0]             cvc_q, cvc_d;
    logic                                head_q, head_d;
    logic                                tail_q, tail_d;
    logic [flit_data_width-1:0]          data_q, data_d;

    logic                                ready;
    logic                                send_ok;
    logic [cred_w:0]                     sum;
    logic                                fc_valid;
    logic [vc_idx_width-1:0]             fc_vc;

    assign fc_valid = bus.flow_ctrl[vc_idx_width];
    assign fc_vc    = bus.flow_ctrl[vc_idx_width-1:0];

    always_comb begin
        state_d     = state_q;
        vc_d        = vc_q;
        len_d       = len_q;
        idx_d       = idx_q;
        route_d     = route_q;
        seq_d       = seq_q;
        pkt_count_d = pkt_count_q;
        error_d     = error_q;
        credit_d    = credit_q;
        link_d      = 1'b0;
        valid_d     = 1'b0;
        head_d      = 1'b0;
        tail_d      = 1'b0;
        cvc_d       = cvc_q;
        data_d      = data_q;
        ready       = 1'b0;
        send_ok     = 1'b0;
        sum         = '0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.pkt_req_valid) begin
                    vc_d    = bus.pkt_req_vc;
                    len_d   = bus.pkt_req_length;
                    route_d = bus.pkt_req_route_info;
                    idx_d   = '0;
                    seq_d   = pkt_count_q;
                    if ({1'b0, bus.pkt_req_vc} < num_vcs_c) begin
                        state_d = SEND;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            SEND: begin
                link_d = 1'b1;
                if (credit_q[vc_q] != '0) begin
                    send_ok = 1'b1;
                    valid_d = 1'b1;
                    head_d  = (idx_q == '0);
                    tail_d  = (idx_q == len_q);
                    cvc_d   = vc_q;
                    data_d  = {route_q, 8'(idx_q), {pad_w{1'b0}}, seq_q, router_address_i};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == len_q) begin
                        state_d     = IDLE;
                        pkt_count_d = pkt_count_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // a send and a return on the same VC cancel; overflow saturates and flags
        for (int v = 0; v < num_vcs; v++) begin
            sum = {1'b0, credit_q[v]};
            if (fc_valid && fc_vc == vc_idx_width'(v)) begin
                sum = sum + 1'b1;
            end
            if (send_ok && vc_q == vc_idx_width'(v)) begin
                sum = sum - 1'b1;
            end
            if (sum > {1'b0, cred_max}) begin
                credit_d[v] = cred_max;
                error_d     = 1'b1;
            end else begin
                credit_d[v] = sum[cred_w-1:0];
            end
        end
        if (fc_valid && {1'b0, fc_vc} >= num_vcs_c) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            vc_q        <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            route_q     <= '0;
            seq_q       <= '0;
            pkt_count_q <= '0;
            error_q     <= 1'b0;
            for (int v = 0; v < num_vcs; v++) begin
                credit_q[v] <= cred_max;
            end
            link_q      <= 1'b0;
            valid_q     <= 1'b0;
            cvc_q       <= '0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            vc_q        <= vc_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            route_q     <= route_d;
            seq_q       <= seq_d;
            pkt_count_q <= pkt_count_d;
            error_q     <= error_d;
            credit_q    <= credit_d;
            link_q      <= link_d;
            valid_q     <= valid_d;
            cvc_q       <= cvc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            data_q      <= data_d;
        end
    end

    assign bus.pkt_req_ready = ready;
    assign bus.channel       = {link_q, valid_q, cvc_q, head_q, tail_q, data_q};
    assign pkt_count_o       = pkt_count_q;
    assign error_o           = error_q;

endmodule
